// File: rtl/mips_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mips_pkg
//  Description : Shared constants and types for the MIPS single-cycle
//                datapath register file and its write-select qualifier.
//  Revision    : 1.0  initial release
// ============================================================================
package mips_pkg;

    localparam int REG_W      = 32;   // architectural register width
    localparam int NUM_REGS   = 32;   // GPR count, equals decoder width
    localparam int REG_ADDR_W = 5;    // log2(NUM_REGS)
    localparam int ZERO_REG   = 0;    // index of the hardwired $zero
    localparam int ERR_CNT_W  = 8;    // width of the malformed-select counter

    typedef logic [REG_W-1:0]    reg_word_t;
    typedef logic [NUM_REGS-1:0] reg_onehot_t;

endpackage : mips_pkg
`default_nettype wire

// File: rtl/reg_file_onehot_wr_onehot_check.sv
`default_nettype none
// ============================================================================
//  Module      : onehot_check
//  Description : Combinational one-hot qualifier for the decoded write select.
//                Reports whether exactly one bit is set and the binary index
//                of that bit.
//  Ports       : i_sel       - N-bit select vector
//                o_is_onehot - 1 when exactly one bit of i_sel is set
//                o_index     - encoded position of the set bit (only
//                              meaningful when o_is_onehot is 1)
//  Revision    : 1.0  initial release
// ============================================================================
module onehot_check
    import mips_pkg::*;
#(
    parameter int N      = NUM_REGS,
    parameter int ADDR_W = REG_ADDR_W
) (
    input  logic [N-1:0]      i_sel,
    output logic              o_is_onehot,
    output logic [ADDR_W-1:0] o_index
);

    logic              w_seen;
    logic              w_multi;
    logic [ADDR_W-1:0] w_index;

    // Single scan: w_seen marks the first set bit, w_multi any further one.
    // OR-ing the indices is exact when only one bit is set; when several are
    // set the index is garbage but o_is_onehot is already low.
    always_comb begin
        w_seen  = 1'b0;
        w_multi = 1'b0;
        w_index = '0;
        for (int i = 0; i < N; i++) begin
            if (i_sel[i]) begin
                if (w_seen) begin
                    w_multi = 1'b1;
                end
                w_seen  = 1'b1;
                w_index = w_index | ADDR_W'(i);
            end
        end
    end

    assign o_is_onehot = w_seen & ~w_multi;
    assign o_index     = w_index;

endmodule : onehot_check
`default_nettype wire

// File: rtl/reg_file_onehot_wr.sv
`default_nettype none
// ============================================================================
//  Module      : reg_file_onehot_wr
//  Description : 32x32 MIPS general-purpose register file. Two combinational
//                read ports, one clocked write port driven by the one-hot
//                output of the write-address decoder. Register 0 reads as
//                zero and is never written. Non-one-hot selects seen while
//                reg_write is high are rejected and recorded in a sticky
//                flag and a saturating counter.
//  Ports       : clk, rst     - clock, synchronous active-high reset
//                reg_write    - write strobe
//                write_sel    - one-hot register select (bit i -> reg i)
//                write_data   - data to write
//                read_addr1/2 - rs / rt read addresses
//                read_data1/2 - combinational read data
//                sel_err      - sticky malformed-select flag
//                err_count    - saturating malformed-write counter
//  Config      : REG_FILE_WRITE_BYPASS_EN - when defined, a qualified write
//                is forwarded to any read port addressing the same register
//                in the same cycle. Undefined: reads see stored state only.
//  Revision    : 1.0  initial release
// ============================================================================
module reg_file_onehot_wr
    import mips_pkg::*;
#(
    parameter int DATA_W   = REG_W,
    parameter int NUM_REGS = mips_pkg::NUM_REGS,
    parameter int ADDR_W   = REG_ADDR_W
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 reg_write,
    input  logic [NUM_REGS-1:0]  write_sel,
    input  logic [DATA_W-1:0]    write_data,
    input  logic [ADDR_W-1:0]    read_addr1,
    input  logic [ADDR_W-1:0]    read_addr2,
    output logic [DATA_W-1:0]    read_data1,
    output logic [DATA_W-1:0]    read_data2,
    output logic                 sel_err,
    output logic [ERR_CNT_W-1:0] err_count
);

    localparam logic [ADDR_W-1:0] c_zero_addr = ADDR_W'(ZERO_REG);

    logic [DATA_W-1:0]    r_regs [NUM_REGS];
    logic                 r_sel_err;
    logic [ERR_CNT_W-1:0] r_err_cnt;

    logic                 w_is_onehot;
    logic [ADDR_W-1:0]    w_wr_idx;
    logic                 w_wr_en;
    logic                 w_bad_sel;
    logic [DATA_W-1:0]    w_rd1;
    logic [DATA_W-1:0]    w_rd2;

    onehot_check #(
        .N      (NUM_REGS),
        .ADDR_W (ADDR_W)
    ) u_onehot_check (
        .i_sel       (write_sel),
        .o_is_onehot (w_is_onehot),
        .o_index     (w_wr_idx)
    );

    // A select of exactly bit 0 is a legal no-op: it is neither a write
    // nor an error.
    assign w_wr_en   = reg_write & w_is_onehot & (w_wr_idx != c_zero_addr);
    assign w_bad_sel = reg_write & ~w_is_onehot;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                r_regs[i] <= '0;
            end
            r_sel_err <= 1'b0;
            r_err_cnt <= '0;
        end else begin
            // Register 0 is excluded so it stays at its reset value forever.
            for (int i = ZERO_REG + 1; i < NUM_REGS; i++) begin
                if (w_wr_en && (w_wr_idx == ADDR_W'(i))) begin
                    r_regs[i] <= write_data;
                end
            end
            if (w_bad_sel) begin
                r_sel_err <= 1'b1;
                if (r_err_cnt != '1) begin
                    r_err_cnt <= r_err_cnt + ERR_CNT_W'(1);
                end
            end
        end
    end

    always_comb begin
        w_rd1 = r_regs[read_addr1];
        w_rd2 = r_regs[read_addr2];
        if (read_addr1 == c_zero_addr) begin
            w_rd1 = '0;
        end
        if (read_addr2 == c_zero_addr) begin
            w_rd2 = '0;
        end
`ifdef REG_FILE_WRITE_BYPASS_EN
        // w_wr_en already excludes index 0 and malformed selects.
        if (w_wr_en && (read_addr1 == w_wr_idx)) begin
            w_rd1 = write_data;
        end
        if (w_wr_en && (read_addr2 == w_wr_idx)) begin
            w_rd2 = write_data;
        end
`else
`endif
    end

    assign read_data1 = w_rd1;
    assign read_data2 = w_rd2;
    assign sel_err    = r_sel_err;
    assign err_count  = r_err_cnt;

endmodule : reg_file_onehot_wr
`default_nettype wire

// File: doc/reg_file_onehot_wr.md
Name: reg_file_onehot_wr

Overview:
- 32x32 MIPS general-purpose register file for the single-cycle datapath.
- Sits directly downstream of the 5-to-32 write-address decoder and consumes its one-hot output as per-register write enables.
- Provides two combinational read ports for rs/rt and one clocked write port for rd/rt.
- Enforces $zero semantics and flags malformed (non-one-hot) write selects.

Parameters:
- DATA_W, 32, register width in bits.
- NUM_REGS, 32, register count; must equal the decoder output width.
- ADDR_W, 5, read-address width; must equal log2(NUM_REGS).

Ports:
- clk  input  1  sole clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- reg_write  input  1  write strobe from control.
- write_sel  input  NUM_REGS  one-hot write select from the decoder; bit i selects register i.
- write_data  input  DATA_W  data to write.
- read_addr1  input  ADDR_W  rs address.
- read_addr2  input  ADDR_W  rt address.
- read_data1  output  DATA_W  contents of the register at read_addr1.
- read_data2  output  DATA_W  contents of the register at read_addr2.
- sel_err  output  1  sticky flag: a malformed write select was seen.
- err_count  output  8  saturating count of malformed write attempts.

Behaviour:
- Reset:
  - When rst=1 at a clk edge, all registers, sel_err and err_count are cleared to 0.
  - rst has priority over any simultaneous write.
  - Reads during reset return the current register contents. After the reset edge they return 0.
- Write:
  - A write occurs at a clk edge when reg_write=1, write_sel has exactly one bit set at index i, and i!=0. Then reg[i] <= write_data.
  - Latency is 1 cycle; the new value is visible on the read ports after the edge.
- $zero:
  - reg[0] is hardwired to 0 and is never written.
  - A valid write with write_sel=32'h1 is a legal no-op and is not an error.
- Malformed select:
  - Applies when reg_write=1 and popcount(write_sel)!=1, including all-zero and multi-hot values.
  - No register changes.
  - sel_err <= 1 and stays at 1 until reset.
  - err_count increments by 1 and saturates at 255.
- reg_write=0: write_sel is ignored entirely and no error is recorded.
- Read:
  - Reads are purely combinational: read_dataN = reg[read_addrN].
  - Address 0 always returns 0.
  - Both ports may address the same register.
- Same-cycle read and write to one register: the read returns the old value. See the optional feature for the alternative.
- Reset-value table: read_data1=0, read_data2=0, sel_err=0, err_count=0.

Optional Feature:
- Macro REG_FILE_WRITE_BYPASS_EN.
- Defined:
  - When reg_write=1 and write_sel is valid one-hot at index i!=0, any read port with read_addrN==i returns write_data combinationally in the same cycle (write-through).
  - Malformed selects and index 0 never bypass.
- Undefined: reads return stored contents only (old value on a same-cycle hazard).

Decomposition:
- Shared package mips_pkg:
  - constants REG_W=32, NUM_REGS=32, REG_ADDR_W=5, ZERO_REG=0, ERR_CNT_W=8.
  - typedef reg_word_t (REG_W bits).
  - typedef reg_onehot_t (NUM_REGS bits).
- One sub-module, onehot_check:
  - Combinational; inputs NUM_REGS bits.
  - Outputs is_onehot and the encoded index (ADDR_W bits).
  - Used for write qualification and the bypass compare.

Test Plan:
- Reset then read: rst=1 for 1 cycle; read_addr1=5, read_addr2=31 -> read_data1=0, read_data2=0, sel_err=0, err_count=0.
- Basic write/read: reg_write=1, write_sel=32'h0000_0100, write_data=32'hDEAD_BEEF; next cycle read_addr1=8 -> 32'hDEAD_BEEF. Also read_addr2=7 -> 0.
- $zero protection: reg_write=1, write_sel=32'h1, write_data=32'hFFFF_FFFF; read_addr1=0 -> 0, sel_err=0.
- Malformed select:
  - reg_write=1, write_sel=32'h0000_0006, write_data=32'h1234 -> reg1 and reg2 unchanged, sel_err=1, err_count=1.
  - Then write_sel=0 with reg_write=1 -> err_count=2.
  - Then 300 further bad writes -> err_count=255.
  - reg_write=0 with write_sel=32'h3 -> no change.
- Same-cycle hazard: reg31 holds 32'hA; write_sel=32'h8000_0000, write_data=32'hB, read_addr1=31 in the same cycle.
  - Macro undefined -> read_data1=32'hA.
  - Macro defined -> 32'hB.
  - Both builds -> 32'hB after the edge.
- Reset priority: rst=1 with reg_write=1, write_sel=32'h10, write_data=32'h55 -> reg4=0 after the edge and sel_err cleared.
